mitch_mul_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 16x16 truncated Mitchell log multiplier (external, MUL_LAT pipeline stages) between N_REQ requesters.
- Arbitrates operand requests with valid/ready handshakes and registers the granted operands onto the multiplier inputs.
- Tags each issue with its requester ID in a delay line aligned to MUL_LAT.
- Buffers products in a credit-protected response FIFO with a valid/ready output.

---
 rtl/mitch_mul_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_mitch_mul_rr_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mitch_mul_rr_scheduler.sv
// Round-robin scheduler that shares one Mitchell log multiplier among N_REQ requesters; products are tagged and returned through a credit-protected FIFO.
// Build option MITCH_RR_SCHED_OPHOLD_EN: hold multiplier operands on idle cycles instead of clearing them.
module mitch_mul_rr_scheduler #(
  parameter  int N_REQ      = 4,
  parameter  int MUL_LAT    = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [16*N_REQ-1:0]   req_x_i,
  input  logic [16*N_REQ-1:0]   req_y_i,
  output logic [15:0]           mul_x_o,
  output logic [15:0]           mul_y_o,
  input  logic [31:0]           mul_p_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [31:0]           rsp_p_o,
  output logic                  busy_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_DEPTH);

  logic [CW-1:0]   credits, credits_nxt;
  logic [ID_W-1:0] last, win;
  logic [ID_W:0]   idx;
  logic            found, issue, pop;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, last} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!found && req_valid_i[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  // A credit guarantees the product a FIFO slot when it emerges.
  assign issue = found && (credits != '0) && !rst_i;
  assign pop   = rsp_valid_o && rsp_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (issue) req_ready_o[win] = 1'b1;
  end

  always_comb begin
    case ({issue, pop})
      2'b10:   credits_nxt = credits - CW'(1);
      2'b01:   credits_nxt = credits + CW'(1);
      default: credits_nxt = credits;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits <= FULL_CREDITS;
      last    <= ID_W'(N_REQ - 1);
      busy_o  <= 1'b0;
      mul_x_o <= '0;
      mul_y_o <= '0;
    end else begin
      credits <= credits_nxt;
      busy_o  <= (credits_nxt != FULL_CREDITS);
      if (issue) begin
        last    <= win;
        mul_x_o <= req_x_i[win*16 +: 16];
        mul_y_o <= req_y_i[win*16 +: 16];
      end
`ifdef MITCH_RR_SCHED_OPHOLD_EN
      else begin
        mul_x_o <= mul_x_o;
        mul_y_o <= mul_y_o;
      end
`else
      else begin
        mul_x_o <= '0;
        mul_y_o <= '0;
      end
`endif
    end
  end

  // Stage 0 is the issue register; stage MUL_LAT lines up with mul_p_i.
  logic [MUL_LAT:0]           tag_vld;
  logic [MUL_LAT:0][ID_W-1:0] tag_id;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= issue;
      tag_id[0]  <= win;
      for (int k = 1; k <= MUL_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  logic [ID_W+31:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    mem_cnt;
  logic             push, load;

  assign push = tag_vld[MUL_LAT];
  assign load = (mem_cnt != '0) && (!rsp_valid_o || rsp_ready_i);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {tag_id[MUL_LAT], mul_p_i};
  end

  // The head is copied into the output register, so entries never bypass the storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_p_o     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) rd_ptr <= rd_ptr + PW'(1);
      if (push && !load)      mem_cnt <= mem_cnt + CW'(1);
      else if (load && !push) mem_cnt <= mem_cnt - CW'(1);
      if (load) begin
        rsp_valid_o           <= 1'b1;
        {rsp_id_o, rsp_p_o}   <= mem[rd_ptr];
      end else if (pop) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mitch_mul_rr_scheduler.sv
// Bench for mitch_mul_rr_scheduler: random requesters against a queue-based reference of the arbitration, credit and latency rules.
module tb_mitch_mul_rr_scheduler;
  localparam int N_REQ      = 4;
  localparam int MUL_LAT    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = $clog2(N_REQ);
`ifdef MITCH_RR_SCHED_OPHOLD_EN
  localparam bit OPHOLD = 1'b1;
`else
  localparam bit OPHOLD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid, req_ready;
  logic [16*N_REQ-1:0] req_x, req_y;
  logic [15:0]         mul_x, mul_y;
  logic [31:0]         mul_p;
  logic                rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_p;

  always #5 clk = ~clk;

  mitch_mul_rr_scheduler #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_x_i(req_x), .req_y_i(req_y), .mul_x_o(mul_x), .mul_y_o(mul_y), .mul_p_i(mul_p),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_p_o(rsp_p),
    .busy_o(busy)
  );

  // Multiplier stand-in: product is the concatenated operands, delayed MUL_LAT cycles.
  logic [31:0] mpipe [0:8];
  always @(posedge clk) begin
    mpipe[0] <= {mul_x, mul_y};
    for (int i = 1; i < 9; i++) mpipe[i] <= mpipe[i-1];
  end
  generate
    if (MUL_LAT == 0) begin : g_comb
      assign mul_p = {mul_x, mul_y};
    end else begin : g_pipe
      assign mul_p = mpipe[MUL_LAT-1];
    end
  endgenerate

  typedef struct {
    int          id;
    logic [31:0] p;
    int          due;
  } rsp_t;

  rsp_t        q[$];
  rsp_t        exp_head;
  int          checks = 0, failures = 0;
  int          cyc, samp_cyc, last_m, credits_m, n_pop;
  logic [15:0] mulx_m, muly_m;
  int          left [N_REQ];
  bit          gappy;
  int          exp_g, got_g, got_id;
  logic        exp_rv, got_rv, obs_rdy;
  logic [31:0] got_p;

  task automatic model_reset();
    cyc = 0; last_m = N_REQ - 1; credits_m = FIFO_DEPTH;
    q.delete(); mulx_m = '0; muly_m = '0;
  endtask

  // One clock: sample at the falling edge, advance the reference across the rising edge, then update requesters.
  task automatic tick();
    rsp_t        e;
    logic        mpop;
    logic [15:0] gx, gy;
    @(negedge clk);
    samp_cyc = cyc;
    exp_g = -1;
    if (credits_m > 0)
      for (int k = 1; k <= N_REQ; k++) begin
        int i;
        i = (last_m + k) % N_REQ;
        if (exp_g < 0 && req_valid[i]) exp_g = i;
      end
    got_g = -1;
    for (int i = 0; i < N_REQ; i++) if (req_ready[i]) got_g = (got_g == -1) ? i : -2;
    exp_rv = 1'b0;
    exp_head.id = -1; exp_head.p = '0; exp_head.due = 0;
    if (q.size() > 0) begin
      exp_head = q[0];
      exp_rv = (cyc >= q[0].due);
    end
    got_rv = rsp_valid; got_id = int'(rsp_id); got_p = rsp_p; obs_rdy = rsp_ready;
    mpop = exp_rv && rsp_ready;
    gx = '0; gy = '0;
    if (exp_g >= 0) begin gx = req_x[exp_g*16 +: 16]; gy = req_y[exp_g*16 +: 16]; end
    @(posedge clk);
    cyc++;
    if (exp_g >= 0) begin
      e.id = exp_g; e.p = {gx, gy}; e.due = cyc + MUL_LAT + 2;
      q.push_back(e);
      last_m = exp_g; credits_m--; mulx_m = gx; muly_m = gy;
    end else if (!OPHOLD) begin
      mulx_m = '0; muly_m = '0;
    end
    if (mpop) begin void'(q.pop_front()); credits_m++; n_pop++; end
    #1;
    if (exp_g >= 0) begin
      left[exp_g]--;
      req_x[exp_g*16 +: 16] = 16'($urandom);
      req_y[exp_g*16 +: 16] = 16'($urandom);
      req_valid[exp_g] = (left[exp_g] > 0) && !gappy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    #12;
    checks++;
    if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    checks++;
    if ({mul_x, mul_y} !== 32'h0) begin failures++; $display("FAIL reset_mul got=%h exp=0", {mul_x, mul_y}); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_p} !== '0) begin failures++; $display("FAIL reset_rsp got=%b/%0d/%h exp=0", rsp_valid, rsp_id, rsp_p); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    int first_rv, start_pop;
    first_rv = -1; start_pop = n_pop;
    gappy = 1'b1; rsp_ready = 1'b1; left[0] = 1;
    req_x[15:0] = 16'h0003; req_y[15:0] = 16'h0005; req_valid = 4'b0001;
    for (int n = 0; n < MUL_LAT + 8; n++) begin
      tick();
      if (n == 0) begin
        checks++;
        if (got_g !== 0) begin failures++; $display("FAIL single_first_grant got=%0d exp=0", got_g); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_rise got=%b exp=1", busy); end
      end
      checks++;
      if (got_g !== exp_g) begin failures++; $display("FAIL single_grant cyc=%0d got=%0d exp=%0d", samp_cyc, got_g, exp_g); end
      checks++;
      if (got_rv !== exp_rv) begin failures++; $display("FAIL single_rsp_valid cyc=%0d got=%b exp=%b", samp_cyc, got_rv, exp_rv); end
      if (got_rv && first_rv < 0) begin
        first_rv = samp_cyc;
        checks++;
        if (got_id !== 0 || got_p !== 32'h00030005) begin
          failures++; $display("FAIL single_payload got=%0d/%h exp=0/00030005", got_id, got_p);
        end
      end
    end
    checks++;
    if (first_rv !== MUL_LAT + 3) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", first_rv, MUL_LAT + 3); end
    checks++;
    if (busy !== 1'b0 || n_pop - start_pop !== 1) begin
      failures++; $display("FAIL single_busy_fall got=%b pops=%0d exp=0 pops=1", busy, n_pop - start_pop);
    end
  endtask

  task automatic test_round_robin();
    int gl[$];
    int start_pop;
    bit done;
    start_pop = n_pop; done = 1'b0;
    gappy = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      left[i] = 6; req_x[i*16 +: 16] = 16'($urandom); req_y[i*16 +: 16] = 16'($urandom);
    end
    req_valid = '1;
    for (int n = 0; n < 300; n++) begin
      if (req_valid == '0 && q.size() == 0) begin done = 1'b1; break; end
      tick();
      if (got_g >= 0) gl.push_back(got_g);
      checks++;
      if (got_g !== exp_g) begin failures++; $display("FAIL rr_grant cyc=%0d got=%0d exp=%0d", samp_cyc, got_g, exp_g); end
      checks++;
      if (got_rv !== exp_rv) begin failures++; $display("FAIL rr_rsp_valid cyc=%0d got=%b exp=%b", samp_cyc, got_rv, exp_rv); end
      if (exp_rv && got_rv) begin
        checks++;
        if (got_id !== exp_head.id || got_p !== exp_head.p) begin
          failures++; $display("FAIL rr_payload got=%0d/%h exp=%0d/%h", got_id, got_p, exp_head.id, exp_head.p);
        end
      end
      checks++;
      if (mul_x !== mulx_m || mul_y !== muly_m) begin
        failures++; $display("FAIL rr_operands got=%h/%h exp=%h/%h", mul_x, mul_y, mulx_m, muly_m);
      end
    end
    checks++;
    if (!done) begin failures++; $display("FAIL rr_timeout got=not_drained exp=drained"); end
    if (gl.size() >= 8)
      for (int k = 1; k < 8; k++) begin
        checks++;
        if (gl[k] !== (gl[0] + k) % N_REQ) begin failures++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, gl[k], (gl[0] + k) % N_REQ); end
      end
    checks++;
    if (n_pop - start_pop !== 6 * N_REQ) begin failures++; $display("FAIL rr_count got=%0d exp=%0d", n_pop - start_pop, 6 * N_REQ); end
  endtask

  task automatic test_backpressure();
    int ngr, start_pop;
    bit done;
    ngr = 0; start_pop = n_pop; done = 1'b0;
    gappy = 1'b0; rsp_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) left[i] = 3;
    req_valid = '1;
    for (int n = 0; n < MUL_LAT + 10; n++) begin
      tick();
      if (got_g >= 0) ngr++;
      checks++;
      if (got_rv !== exp_rv) begin failures++; $display("FAIL bp_rsp_valid cyc=%0d got=%b exp=%b", samp_cyc, got_rv, exp_rv); end
      if (exp_rv && got_rv) begin
        checks++;
        if (got_id !== exp_head.id || got_p !== exp_head.p) begin
          failures++; $display("FAIL bp_hold got=%0d/%h exp=%0d/%h", got_id, got_p, exp_head.id, exp_head.p);
        end
      end
    end
    checks++;
    if (ngr !== FIFO_DEPTH) begin failures++; $display("FAIL bp_grants got=%0d exp=%0d", ngr, FIFO_DEPTH); end
    checks++;
    if (req_ready !== '0) begin failures++; $display("FAIL bp_stalled got=%b exp=0", req_ready); end
    rsp_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (req_valid == '0 && q.size() == 0) begin done = 1'b1; break; end
      tick();
      if (n == 1) begin
        checks++;
        if (!(got_g >= 0 && got_rv)) begin
          failures++; $display("FAIL bp_issue_with_pop got=grant%0d/valid%b exp=grant+valid", got_g, got_rv);
        end
      end
      checks++;
      if (got_g !== exp_g) begin failures++; $display("FAIL bp_grant cyc=%0d got=%0d exp=%0d", samp_cyc, got_g, exp_g); end
      checks++;
      if (got_rv !== exp_rv) begin failures++; $display("FAIL bp_rsp_valid2 cyc=%0d got=%b exp=%b", samp_cyc, got_rv, exp_rv); end
      if (exp_rv && got_rv) begin
        checks++;
        if (got_id !== exp_head.id || got_p !== exp_head.p) begin
          failures++; $display("FAIL bp_payload got=%0d/%h exp=%0d/%h", got_id, got_p, exp_head.id, exp_head.p);
        end
      end
      rsp_ready = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    checks++;
    if (!done) begin failures++; $display("FAIL bp_timeout got=not_drained exp=drained"); end
    checks++;
    if (n_pop - start_pop !== 3 * N_REQ) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", n_pop - start_pop, 3 * N_REQ); end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    gappy = 1'b1;
    for (int i = 0; i < N_REQ; i++) left[i] = $urandom_range(2, 10);
    for (int n = 0; n < 1500; n++) begin
      bit all_done;
      all_done = (q.size() == 0) && (req_valid == '0);
      for (int i = 0; i < N_REQ; i++) if (left[i] > 0) all_done = 1'b0;
      if (all_done) begin done = 1'b1; break; end
      for (int i = 0; i < N_REQ; i++)
        if (!req_valid[i] && left[i] > 0 && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (got_g !== exp_g) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%0d exp=%0d", samp_cyc, got_g, exp_g); end
      checks++;
      if (got_rv !== exp_rv) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", samp_cyc, got_rv, exp_rv); end
      if (exp_rv && got_rv) begin
        checks++;
        if (got_id !== exp_head.id || got_p !== exp_head.p) begin
          failures++; $display("FAIL rnd_payload got=%0d/%h exp=%0d/%h", got_id, got_p, exp_head.id, exp_head.p);
        end
      end
      checks++;
      if (busy !== (credits_m != FIFO_DEPTH)) begin failures++; $display("FAIL rnd_busy got=%b exp=%b", busy, credits_m != FIFO_DEPTH); end
    end
    checks++;
    if (!done) begin failures++; $display("FAIL rnd_timeout got=not_drained exp=drained"); end
  endtask

  task automatic test_idle_operand();
    bit granted;
    granted = 1'b0;
    gappy = 1'b1; rsp_ready = 1'b1; left[1] = 1;
    req_x[31:16] = 16'hBEEF; req_y[31:16] = 16'h1234; req_valid = 4'b0010;
    for (int n = 0; n < 5 && !granted; n++) begin
      tick();
      granted = (got_g == 1);
    end
    checks++;
    if (!granted) begin failures++; $display("FAIL idle_grant got=none exp=1"); end
    tick(); tick();
    checks++;
    if (mul_x !== (OPHOLD ? 16'hBEEF : 16'h0000) || mul_y !== (OPHOLD ? 16'h1234 : 16'h0000)) begin
      failures++; $display("FAIL idle_operands got=%h/%h exp=%h/%h", mul_x, mul_y,
                           OPHOLD ? 16'hBEEF : 16'h0000, OPHOLD ? 16'h1234 : 16'h0000);
    end
    for (int n = 0; n < MUL_LAT + 6; n++) tick();
    checks++;
    if (q.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL idle_drain got=q%0d/busy%b exp=q0/busy0", q.size(), busy); end
  endtask

  task automatic test_reset_mid();
    int start_pop, n_iss;
    bit done;
    done = 1'b0; n_iss = 0;
    gappy = 1'b0; rsp_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) left[i] = 3;
    req_valid = '1;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0 || {mul_x, mul_y} !== 32'h0) begin
      failures++; $display("FAIL mid_reset_issue got=%b/%h exp=0/0", req_ready, {mul_x, mul_y});
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_p, busy} !== '0) begin
      failures++; $display("FAIL mid_reset_rsp got=%b/%0d/%h/%b exp=0", rsp_valid, rsp_id, rsp_p, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    start_pop = n_pop;
    rsp_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (req_valid == '0 && q.size() == 0) begin done = 1'b1; break; end
      tick();
      if (exp_g >= 0) n_iss++;
      if (n == 0) begin
        checks++;
        if (got_g !== 0) begin failures++; $display("FAIL mid_first_grant got=%0d exp=0", got_g); end
      end
      checks++;
      if (got_g !== exp_g) begin failures++; $display("FAIL mid_grant cyc=%0d got=%0d exp=%0d", samp_cyc, got_g, exp_g); end
      checks++;
      if (got_rv !== exp_rv) begin failures++; $display("FAIL mid_rsp_valid cyc=%0d got=%b exp=%b", samp_cyc, got_rv, exp_rv); end
      if (exp_rv && got_rv) begin
        checks++;
        if (got_id !== exp_head.id || got_p !== exp_head.p) begin
          failures++; $display("FAIL mid_payload got=%0d/%h exp=%0d/%h", got_id, got_p, exp_head.id, exp_head.p);
        end
      end
    end
    checks++;
    if (!done) begin failures++; $display("FAIL mid_timeout got=not_drained exp=drained"); end
    checks++;
    if (n_pop - start_pop !== n_iss) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", n_pop - start_pop, n_iss); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_x = '0; req_y = '0;
    n_pop = 0; gappy = 1'b0;
    for (int i = 0; i < N_REQ; i++) left[i] = 0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_random();
    test_idle_operand();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
